// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the PWM time-base.
// Latency: n/a (declarations only). Backpressure: n/a.
package pwm_pkg;

    localparam int PWM_WIDTH_DEF   = 16;
    localparam int PWM_MAX_PSC_DEF = 15;

    typedef enum logic [1:0] {
        MODE_UP      = 2'd0,
        MODE_DOWN    = 2'd1,
        MODE_UPDOWN  = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Power-of-two divider: tick every 2^N enabled, unfrozen cycles; fire is combinational, tick registered.
// Latency: tick one cycle after the counting edge. Backpressure: none, en/freeze simply hold the partial count.
module pwm_prescaler #(
    parameter int MAX_PSC = 15,
    parameter int PSC_W   = $clog2(MAX_PSC + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             freeze,
    input  logic             clear,
    input  logic [PSC_W-1:0] prescale,
    output logic             fire,
    output logic             tick
);

    localparam int LW = MAX_PSC + 1;

    logic [MAX_PSC-1:0] psc_cnt_q, psc_cnt_d;
    logic               tick_q, tick_d;
    logic [31:0]        n_ext;
    logic [31:0]        n_eff;
    logic [LW-1:0]      limit;

    always_comb begin
        n_ext = 32'(prescale);
        n_eff = (n_ext > 32'(MAX_PSC)) ? 32'(MAX_PSC) : n_ext;
        limit = (LW'(1) << n_eff) - LW'(1);

        // >= rather than == so lowering N mid-count fires at once instead of wrapping
        fire  = en && !freeze && ({1'b0, psc_cnt_q} >= limit);

        psc_cnt_d = psc_cnt_q;
        if (clear) begin
            psc_cnt_d = '0;
        end else if (en && !freeze) begin
            psc_cnt_d = fire ? '0 : psc_cnt_q + MAX_PSC'(1);
        end
        tick_d = fire && !clear;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            psc_cnt_q <= psc_cnt_d;
            tick_q    <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/pwm_timebase.sv
// PWM time-base: prescaled WIDTH-bit counter (up/down/centre/one-shot) with double-buffered period and mode.
// Latency: count and pulses update on the edge the prescaler fires. Backpressure: none, en freezes the time-base.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int WIDTH   = PWM_WIDTH_DEF,
    parameter int MAX_PSC = PWM_MAX_PSC_DEF,
    parameter int PSC_W   = $clog2(MAX_PSC + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             count_reset,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] period,
    input  logic [PSC_W-1:0] prescale,
    output logic [WIDTH-1:0] count_val,
    output logic             dir,
    output logic             tick,
    output logic             ovf,
    output logic             unf,
    output logic             done
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] act_period_q, act_period_d;
    mode_t            act_mode_q, act_mode_d;
    logic             dir_q, dir_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             done_q, done_d;
    logic             psc_fire;
    logic             upd_evt;
    logic [WIDTH-1:0] p;

    pwm_prescaler #(
        .MAX_PSC (MAX_PSC),
        .PSC_W   (PSC_W)
    ) u_psc (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .freeze   (done_q),
        .clear    (count_reset),
        .prescale (prescale),
        .fire     (psc_fire),
        .tick     (tick)
    );

    always_comb begin
        p       = act_period_q;
        count_d = count_q;
        dir_d   = dir_q;
        done_d  = done_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;

        if (psc_fire) begin
            case (act_mode_q)
                MODE_UP: begin
                    dir_d = 1'b1;
                    if (count_q >= p) begin
                        count_d = '0;
                        ovf_d   = 1'b1;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
                MODE_DOWN: begin
                    dir_d = 1'b0;
                    if (count_q == '0) begin
                        count_d = p;
                        unf_d   = 1'b1;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
                MODE_UPDOWN: begin
                    // a zero period degenerates to a stuck-at-0 up counter
                    if (p == '0) begin
                        count_d = '0;
                        ovf_d   = 1'b1;
                        dir_d   = 1'b1;
                    end else if (dir_q) begin
                        if (count_q >= p) begin
                            count_d = p - WIDTH'(1);
                            ovf_d   = 1'b1;
                            dir_d   = 1'b0;
                        end else begin
                            count_d = count_q + WIDTH'(1);
                        end
                    end else begin
                        if (count_q == '0) begin
                            count_d = WIDTH'(1);
                            unf_d   = 1'b1;
                            dir_d   = 1'b1;
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                end
                MODE_ONESHOT: begin
                    dir_d = 1'b1;
                    if (count_q >= p) begin
                        count_d = p;
                        ovf_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end

        // shadow load: the event edge still used the old period/mode above
        upd_evt      = ovf_d || unf_d;
        act_period_d = act_period_q;
        act_mode_d   = act_mode_q;
        if (!en || count_reset || upd_evt) begin
            act_period_d = period;
            act_mode_d   = mode_t'(mode);
        end

        if (count_reset) begin
            count_d = '0;
            dir_d   = (mode_t'(mode) != MODE_DOWN);
            done_d  = 1'b0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            dir_q        <= 1'b1;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            done_q       <= 1'b0;
            act_period_q <= '0;
            act_mode_q   <= MODE_UP;
        end else begin
            count_q      <= count_d;
            dir_q        <= dir_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            done_q       <= done_d;
            act_period_q <= act_period_d;
            act_mode_q   <= act_mode_d;
        end
    end

    assign count_val = count_q;
    assign dir       = dir_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pwm_timebase.sv
// Directed table-driven bench for pwm_timebase plus hand-written multi-cycle sequences.
module tb_pwm_timebase;
    import pwm_pkg::*;

    localparam int W  = 16;
    localparam int PW = 4;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          count_reset;
    logic [1:0]    mode;
    logic [W-1:0]  period;
    logic [PW-1:0] prescale;
    logic [W-1:0]  count_val;
    logic          dir, tick, ovf, unf, done;

    int n_checks;
    int n_errors;

    pwm_timebase #(
        .WIDTH   (W),
        .MAX_PSC (15),
        .PSC_W   (PW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .count_reset (count_reset),
        .mode        (mode),
        .period      (period),
        .prescale    (prescale),
        .count_val   (count_val),
        .dir         (dir),
        .tick        (tick),
        .ovf         (ovf),
        .unf         (unf),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic          cr;
        logic [1:0]    mode;
        logic [W-1:0]  period;
        logic [PW-1:0] psc;
        logic [W-1:0]  e_cnt;
        logic          e_dir;
        logic          e_tick;
        logic          e_ovf;
        logic          e_unf;
        logic          e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(int e, int cr, int m, int p, int n,
                               int c, int d, int t, int o, int u, int dn);
        vec_t r;
        r.en     = 1'(e);
        r.cr     = 1'(cr);
        r.mode   = 2'(m);
        r.period = W'(p);
        r.psc    = PW'(n);
        r.e_cnt  = W'(c);
        r.e_dir  = 1'(d);
        r.e_tick = 1'(t);
        r.e_ovf  = 1'(o);
        r.e_unf  = 1'(u);
        r.e_done = 1'(dn);
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] c, input logic d,
                         input logic t, input logic o, input logic u, input logic dn);
        n_checks++;
        if ({count_val, dir, tick, ovf, unf, done} !== {c, d, t, o, u, dn}) begin
            n_errors++;
            $display("FAIL %s: got cnt=%0d dir=%0b tick=%0b ovf=%0b unf=%0b done=%0b, want cnt=%0d dir=%0b tick=%0b ovf=%0b unf=%0b done=%0b",
                     name, count_val, dir, tick, ovf, unf, done, c, d, t, o, u, dn);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b1;
        en          = 1'b0;
        count_reset = 1'b0;
        mode        = MODE_UP;
        period      = '0;
        prescale    = '0;

        // UP P=3 N=0
        vecs.push_back(v(1,1,MODE_UP,3,0, 0,1,0,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,3,0, 1,1,1,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,3,0, 2,1,1,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,3,0, 3,1,1,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,3,0, 0,1,1,1,0,0));
        vecs.push_back(v(1,0,MODE_UP,3,0, 1,1,1,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,3,0, 2,1,1,0,0,0));
        // DOWN P=2 N=1
        vecs.push_back(v(1,1,MODE_DOWN,2,1, 0,0,0,0,0,0));
        vecs.push_back(v(1,0,MODE_DOWN,2,1, 0,0,0,0,0,0));
        vecs.push_back(v(1,0,MODE_DOWN,2,1, 2,0,1,0,1,0));
        vecs.push_back(v(1,0,MODE_DOWN,2,1, 2,0,0,0,0,0));
        vecs.push_back(v(1,0,MODE_DOWN,2,1, 1,0,1,0,0,0));
        vecs.push_back(v(1,0,MODE_DOWN,2,1, 1,0,0,0,0,0));
        vecs.push_back(v(1,0,MODE_DOWN,2,1, 0,0,1,0,0,0));
        vecs.push_back(v(1,0,MODE_DOWN,2,1, 0,0,0,0,0,0));
        vecs.push_back(v(1,0,MODE_DOWN,2,1, 2,0,1,0,1,0));
        // UPDOWN P=3 N=0
        vecs.push_back(v(1,1,MODE_UPDOWN,3,0, 0,1,0,0,0,0));
        vecs.push_back(v(1,0,MODE_UPDOWN,3,0, 1,1,1,0,0,0));
        vecs.push_back(v(1,0,MODE_UPDOWN,3,0, 2,1,1,0,0,0));
        vecs.push_back(v(1,0,MODE_UPDOWN,3,0, 3,1,1,0,0,0));
        vecs.push_back(v(1,0,MODE_UPDOWN,3,0, 2,0,1,1,0,0));
        vecs.push_back(v(1,0,MODE_UPDOWN,3,0, 1,0,1,0,0,0));
        vecs.push_back(v(1,0,MODE_UPDOWN,3,0, 0,0,1,0,0,0));
        vecs.push_back(v(1,0,MODE_UPDOWN,3,0, 1,1,1,0,1,0));
        vecs.push_back(v(1,0,MODE_UPDOWN,3,0, 2,1,1,0,0,0));
        // shadow period: 5 -> 2 written while count=1
        vecs.push_back(v(1,1,MODE_UP,5,0, 0,1,0,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,5,0, 1,1,1,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,2,0, 2,1,1,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,2,0, 3,1,1,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,2,0, 4,1,1,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,2,0, 5,1,1,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,2,0, 0,1,1,1,0,0));
        vecs.push_back(v(1,0,MODE_UP,2,0, 1,1,1,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,2,0, 2,1,1,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,2,0, 0,1,1,1,0,0));
        // count_reset coincident with a top tick
        vecs.push_back(v(1,1,MODE_UP,2,0, 0,1,0,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,2,0, 1,1,1,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,2,0, 2,1,1,0,0,0));
        vecs.push_back(v(1,1,MODE_UP,2,0, 0,1,0,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,2,0, 1,1,1,0,0,0));
        // en drop mid-prescale keeps the partial count (N=2)
        vecs.push_back(v(1,1,MODE_UP,7,2, 0,1,0,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,7,2, 0,1,0,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,7,2, 0,1,0,0,0,0));
        vecs.push_back(v(0,0,MODE_UP,7,2, 0,1,0,0,0,0));
        vecs.push_back(v(0,0,MODE_UP,7,2, 0,1,0,0,0,0));
        vecs.push_back(v(0,0,MODE_UP,7,2, 0,1,0,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,7,2, 0,1,0,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,7,2, 1,1,1,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,7,2, 1,1,0,0,0,0));
        // lowering N mid-count ticks immediately
        vecs.push_back(v(1,1,MODE_UP,7,2, 0,1,0,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,7,2, 0,1,0,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,7,2, 0,1,0,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,7,1, 1,1,1,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,7,1, 1,1,0,0,0,0));
        vecs.push_back(v(1,0,MODE_UP,7,1, 2,1,1,0,0,0));
        // ONESHOT P=4
        vecs.push_back(v(1,1,MODE_ONESHOT,4,0, 0,1,0,0,0,0));
        vecs.push_back(v(1,0,MODE_ONESHOT,4,0, 1,1,1,0,0,0));
        vecs.push_back(v(1,0,MODE_ONESHOT,4,0, 2,1,1,0,0,0));
        vecs.push_back(v(1,0,MODE_ONESHOT,4,0, 3,1,1,0,0,0));
        vecs.push_back(v(1,0,MODE_ONESHOT,4,0, 4,1,1,0,0,0));
        vecs.push_back(v(1,0,MODE_ONESHOT,4,0, 4,1,1,1,0,1));
        vecs.push_back(v(1,0,MODE_ONESHOT,4,0, 4,1,0,0,0,1));

        #1 rst_n = 1'b0;
        #1 check("reset_state", 0, 1, 0, 0, 0, 0);
        #6 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            en          = vecs[i].en;
            count_reset = vecs[i].cr;
            mode        = vecs[i].mode;
            period      = vecs[i].period;
            prescale    = vecs[i].psc;
            step();
            check($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_dir, vecs[i].e_tick,
                  vecs[i].e_ovf, vecs[i].e_unf, vecs[i].e_done);
        end

        // one-shot stays parked, done survives en low, count_reset rearms
        for (int i = 0; i < 20; i++) begin
            step();
            check("oneshot_hold", 4, 1, 0, 0, 0, 1);
        end
        en = 1'b0;
        step();
        check("oneshot_en_low", 4, 1, 0, 0, 0, 1);
        step();
        check("oneshot_en_low2", 4, 1, 0, 0, 0, 1);
        en = 1'b1;
        step();
        check("oneshot_reenable", 4, 1, 0, 0, 0, 1);
        count_reset = 1'b1;
        step();
        check("oneshot_clear", 0, 1, 0, 0, 0, 0);
        count_reset = 1'b0;
        step();
        check("oneshot_restart", 1, 1, 1, 0, 0, 0);

        // async reset mid-count, then reset-time shadow values (UP, P=0) govern the first tick
        mode        = MODE_DOWN;
        period      = W'(5);
        prescale    = '0;
        count_reset = 1'b1;
        step();
        check("down_clear_dir", 0, 0, 0, 0, 0, 0);
        count_reset = 1'b0;
        step();
        check("down_first", 5, 0, 1, 0, 1, 0);
        step();
        check("down_4", 4, 0, 1, 0, 0, 0);
        step();
        check("down_3", 3, 0, 1, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 0, 1, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        step();
        check("post_reset_p0", 0, 1, 1, 1, 0, 0);
        step();
        check("post_reset_down", 5, 0, 1, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_timebase.md
# pwm_timebase

Parametrised PWM time-base counter: a power-of-two prescaler feeding a WIDTH-bit counter with up, down, up/down (centre-aligned) and one-shot modes. Period and mode are double-buffered and take effect only at update events. Registered overflow/underflow pulses and direction are provided for downstream compare/output stages. Sits between the register file and the PWM compare channels; supersedes the fixed 16-bit up/down counter.

## Interface
- WIDTH, 16: counter and period width
- MAX_PSC, 15: largest prescale exponent accepted; prescaler counter is MAX_PSC bits
- PSC_W, $clog2(MAX_PSC+1): width of the prescale port
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  count enable
- count_reset  in  1  synchronous clear; priority over en
- mode  in  2  0 UP, 1 DOWN, 2 UPDOWN, 3 ONESHOT (shadow)
- period  in  WIDTH  terminal value P (shadow)
- prescale  in  PSC_W  exponent N; tick every 2^N enabled cycles; values > MAX_PSC clamp to MAX_PSC
- count_val  out  WIDTH  counter value
- dir  out  1  1 = counting up
- tick  out  1  registered prescaler tick (one cycle)
- ovf  out  1  one-cycle pulse at top event
- unf  out  1  one-cycle pulse at bottom event
- done  out  1  one-shot finished, sticky

## Operation
- Active registers act_period and act_mode are loaded from the inputs:
  - every cycle while en=0;
  - on count_reset;
  - at every update event (a top or bottom event).
- Otherwise they hold, so mid-period writes are glitch-free.
- Prescaler: psc_cnt increments each cycle with en=1 and done=0. When psc_cnt >= 2^N-1, a tick fires and psc_cnt returns to 0. The >= compare means lowering N mid-count fires a tick immediately.
- On a tick, with P = act_period:
  - UP: count >= P gives count=0 and ovf; else count+1.
  - DOWN: count == 0 gives count=P and unf; else count-1.
  - UPDOWN, dir=1: count >= P gives top event (ovf, dir<=0, count<=P-1); else count+1.
  - UPDOWN, dir=0: count == 0 gives bottom event (unf, dir<=1, count<=1); else count-1.
  - ONESHOT: count >= P gives ovf, done<=1, count holds at P, prescaler freezes; else count+1.
- P=0:
  - UP, UPDOWN and ONESHOT: count stays 0 and ovf fires every tick; dir stays 1.
  - DOWN: unf fires every tick.
- dir is 1 in UP and ONESHOT, 0 in DOWN, and toggles in UPDOWN.
- done is cleared only by count_reset or rst_n. Dropping en does not clear done.
- rst_n=0 or count_reset=1 sets:
  - count_val=0, psc_cnt=0, tick=ovf=unf=done=0;
  - dir=1, except dir=0 when the incoming mode is DOWN.
- DOWN after a clear therefore starts at 0 and reloads P on its first tick, with unf.

## Timing
- All outputs are registered. Reset values: count_val=0, dir=1, tick=0, ovf=0, unf=0, done=0, act_period=0, act_mode=UP.
- N=0, en=1: count_val changes on every rising edge; the first change is at the first edge that samples en=1.
- tick, ovf and unf are high in the same cycle the new count_val appears, for exactly one cycle.
- Period/mode written at an update event are used from the next tick onward. The event itself uses the old P.
- Simultaneous count_reset and tick: the reset wins and no pulse is issued.
- en deasserted mid-prescale freezes psc_cnt. Re-enabling resumes without losing the partial count.
- rst_n assertion mid-count clears everything asynchronously. Deassertion is expected to be synchronised upstream.

## Structure
- Package pwm_pkg holds:
  - the mode_t enum (MODE_UP, MODE_DOWN, MODE_UPDOWN, MODE_ONESHOT);
  - the default WIDTH and MAX_PSC localparams.
- Sub-module pwm_prescaler (en, freeze, prescale, clear → tick) isolates the power-of-two divider.
- The top level contains the shadow registers and the mode state machine.

## Test plan
- UP, P=3, N=0: count 0,1,2,3,0,1…; ovf high in each cycle count returns to 0; tick high every cycle.
- DOWN, P=2, N=1 after count_reset: ticks every 2 cycles; count 0→2 (unf), 1, 0, 2 (unf).
- UPDOWN, P=3, N=0: count 0,1,2,3,2,1,0,1; ovf when 2 follows 3; unf when 1 follows 0; dir falls with ovf.
- ONESHOT, P=4: reaches 4, ovf once, done=1, count holds for ≥20 cycles with en=1; count_reset restores count=0, done=0.
- Shadow check, UP: change period 5→2 while count=1; old P=5 runs to wrap, then 0,1,2,0.
- Clear priority: count_reset together with a top tick gives count=0 and ovf=0. rst_n pulsed mid-count sets all outputs to reset values within the same cycle.
